// File: rtl/dut_if_pkg.sv
// dut_if_pkg: shared definitions for the dut A/B->Y bus master slice.
//   - 3-bit dut address map (status reads, data read/writes)
//   - sequencer state enum
//   - default poll limit
//   - helpers that map a poll state to its status address and successor state
package dut_if_pkg;

  localparam logic [2:0] ADDR_A_STATUS = 3'd0; // read: 1 = A FIFO not full
  localparam logic [2:0] ADDR_B_STATUS = 3'd1; // read: 1 = B FIFO not full
  localparam logic [2:0] ADDR_Y_STATUS = 3'd2; // read: 1 = Y FIFO not empty
  localparam logic [2:0] ADDR_Y_DATA   = 3'd3; // read: pops Y
  localparam logic [2:0] ADDR_A_DATA   = 3'd4; // write
  localparam logic [2:0] ADDR_B_DATA   = 3'd5; // write

  localparam int unsigned POLL_LIMIT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_A,
    ST_WR_A,
    ST_POLL_B,
    ST_WR_B,
    ST_POLL_Y,
    ST_RD_Y,
    ST_OUT
  } state_e;

  // Captured operand pair for the transaction in flight.
  typedef struct packed {
    logic a;
    logic b;
  } pair_t;

  function automatic logic [2:0] poll_addr(input state_e s);
    case (s)
      ST_POLL_A: poll_addr = ADDR_A_STATUS;
      ST_POLL_B: poll_addr = ADDR_B_STATUS;
      ST_POLL_Y: poll_addr = ADDR_Y_STATUS;
      default:   poll_addr = 3'd0;
    endcase
  endfunction

  // State entered once a poll sees its status bit set.
  function automatic state_e poll_next(input state_e s);
    case (s)
      ST_POLL_A: poll_next = ST_WR_A;
      ST_POLL_B: poll_next = ST_WR_B;
      ST_POLL_Y: poll_next = ST_RD_Y;
      default:   poll_next = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dut_if_master_if.sv
// dut_if_master_if: bundles the operand input stream, the result output
// stream and the dut write/read method ports seen by dut_if_master.
//   master modport: the sequencer's view (drives ready/valid outs, dut en/addr/data)
//   slave  modport: the environment's view (stimulus source, consumer, dut)
interface dut_if_master_if;

  // operand stream
  logic       in_valid;
  logic       in_ready;
  logic       in_a;
  logic       in_b;
  // result stream
  logic       out_valid;
  logic       out_ready;
  logic       out_y;
  // dut write method
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;
  // dut read method
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  modport master (
    input  in_valid, in_a, in_b, out_ready, write_rdy, read_data, read_rdy,
    output in_ready, out_valid, out_y,
           write_address, write_data, write_en, read_address, read_en
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, write_rdy, read_data, read_rdy,
    input  in_ready, out_valid, out_y,
           write_address, write_data, write_en, read_address, read_en
  );

endinterface

// File: rtl/dut_if_poll_ctr.sv
// dut_if_poll_ctr: consecutive not-ready status read counter.
//   CLK, RST_N : clock, synchronous active-low reset
//   clear      : zero the count (new transaction or successful poll)
//   inc        : one more not-ready read observed this cycle
//   limit_hit  : this inc is the POLL_LIMIT-th consecutive miss
module dut_if_poll_ctr
  import dut_if_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = POLL_LIMIT_DEF,
  localparam int         W          = $clog2(POLL_LIMIT + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic inc,
  output logic limit_hit
);

  localparam logic [W-1:0] LAST = W'(POLL_LIMIT - 1);

  logic [W-1:0] cnt_q;

  // Flagged on the miss itself so the abort lands on the same edge.
  assign limit_hit = inc && (cnt_q == LAST);

  always_ff @(posedge CLK) begin
    if (!RST_N)                  cnt_q <= '0;
    else if (clear || limit_hit) cnt_q <= '0;
    else if (inc)                cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/dut_if_master.sv
// dut_if_master: synthesizable sequencer driving the dut A/B->Y FIFO block.
// Takes one {a,b} pair, polls A status, writes A, polls B status, writes B,
// polls Y status, pops Y, then offers Y downstream. One pair in flight.
//   CLK, RST_N  : clock, synchronous active-low reset
//   bus         : dut_if_master_if.master (streams + dut method ports)
//   timeout_err : sticky, a status poll hit POLL_LIMIT misses
//   txn_count   : completed transactions, wraps at 16 bits
module dut_if_master
  import dut_if_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = POLL_LIMIT_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  dut_if_master_if.master bus,
  output logic            timeout_err,
  output logic [15:0]     txn_count
);

  state_e     state_q;
  pair_t      pair_q;
  logic       y_q;
  logic [15:0] txn_q;

  logic       is_poll, want_rd, want_wr;
  logic [2:0] rd_addr, wr_addr;
  logic       rd_xfer, wr_xfer;
  logic       accept, poll_ok, poll_miss, limit_hit;

  always_comb begin
    is_poll = (state_q == ST_POLL_A) || (state_q == ST_POLL_B) ||
              (state_q == ST_POLL_Y);
    want_rd = is_poll || (state_q == ST_RD_Y);
    want_wr = (state_q == ST_WR_A) || (state_q == ST_WR_B);
    rd_addr = (state_q == ST_RD_Y) ? ADDR_Y_DATA : poll_addr(state_q);
    wr_addr = (state_q == ST_WR_B) ? ADDR_B_DATA : ADDR_A_DATA;
  end

  // en only rises when the slave is ready, so en alone marks a transfer.
  // Gating with RST_N keeps a reset cycle from touching dut.
  assign rd_xfer = RST_N & want_rd & bus.read_rdy;
  assign wr_xfer = RST_N & want_wr & bus.write_rdy;

  assign bus.read_en       = rd_xfer;
  assign bus.read_address  = rd_xfer ? rd_addr : 3'd0;
  assign bus.write_en      = wr_xfer;
  assign bus.write_address = wr_xfer ? wr_addr : 3'd0;
  assign bus.write_data    = wr_xfer &
                             ((state_q == ST_WR_B) ? pair_q.b : pair_q.a);

  // Stream flags are straight decodes of the registered state.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_y     = y_q;
  assign txn_count     = txn_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign poll_ok   = is_poll & rd_xfer &  bus.read_data;
  assign poll_miss = is_poll & rd_xfer & ~bus.read_data;

  dut_if_poll_ctr #(.POLL_LIMIT(POLL_LIMIT)) u_poll_ctr (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clear    (accept | poll_ok),
    .inc      (poll_miss),
    .limit_hit(limit_hit)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      pair_q      <= '0;
      y_q         <= 1'b0;
      timeout_err <= 1'b0;
      txn_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            pair_q  <= '{a: bus.in_a, b: bus.in_b};
            state_q <= ST_POLL_A;
          end
        end
        ST_POLL_A, ST_POLL_B, ST_POLL_Y: begin
          if (poll_ok) begin
            state_q <= poll_next(state_q);
          end else if (limit_hit) begin
            // Abandon the pair; partial pushes already in dut stay there.
            timeout_err <= 1'b1;
            pair_q      <= '0;
            state_q     <= ST_IDLE;
          end
        end
        ST_WR_A: if (wr_xfer) state_q <= ST_POLL_B;
        ST_WR_B: if (wr_xfer) state_q <= ST_POLL_Y;
        ST_RD_Y: begin
          if (rd_xfer) begin
            y_q     <= bus.read_data;
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            txn_q   <= txn_q + 16'd1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
